// File: rtl/major_state_seq.sv
// PDP-8/e major-state sequencer: walks F/D/E/H cycles, memory stalls, interrupt entry and run control.
// Build option SINGLE_STEP_EN: the SING STEP switch halts at every instruction boundary.
module major_state_seq #(
    parameter bit START_HALTED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:11] instruction,
    input  logic        mem_busy,
    input  logic        int_req,
    input  logic        ion_set,
    input  logic        iof_set,
    input  logic        hlt_instr,
    input  logic        halt_sw,
    input  logic        cont_pulse,
    input  logic        sing_step_sw,
    output logic [4:0]  state,
    output logic        int_in_prog,
    output logic        int_enable,
    output logic        run,
    output logic        instr_done
);

    // state | meaning
    // F0    | fetch start, memory read issued
    // FW    | fetch memory wait
    // F1-F2 | fetch data / IR load (IR valid from F2)
    // F3    | decode; boundary for JMP direct, IOT, OPR
    // D0-D3 | defer (indirect address) cycle, D0 waits on memory
    // E0-E3 | execute cycle, also the forced JMS 0 of an interrupt
    // H0    | halted, waiting for CONT
    // H1-H3 | front-panel start sequence, H3 syncs pc/ma
    typedef enum logic [4:0] {
        ST_F0 = 5'h00, ST_F1 = 5'h01, ST_F2 = 5'h02, ST_F3 = 5'h03, ST_FW = 5'h04,
        ST_D0 = 5'h08, ST_D1 = 5'h09, ST_D2 = 5'h0A, ST_D3 = 5'h0B,
        ST_E0 = 5'h10, ST_E1 = 5'h11, ST_E2 = 5'h12, ST_E3 = 5'h13,
        ST_H0 = 5'h18, ST_H1 = 5'h19, ST_H2 = 5'h1A, ST_H3 = 5'h1B
    } state_t;

    state_t     cur;
    state_t     nxt;
    logic [2:0] op;
    logic       ind;
    logic       boundary;
    logic       halt_now;
    logic       step_now;
    logic       en_eff;
    logic       take_int;
    logic       done_nx;
    logic       halt_nx;
    logic       ion_pending;
    logic       ion_armed;

    assign op    = instruction[0:2];
    assign ind   = instruction[3];
    assign state = cur;

`ifdef SINGLE_STEP_EN
    logic [7:0] unused_instr;
    assign step_now     = sing_step_sw;
    assign unused_instr = instruction[4:11];
`else
    logic [8:0] unused_inputs;
    assign step_now      = 1'b0;
    assign unused_inputs = {instruction[4:11], sing_step_sw};
`endif

    // An IOF in the ending instruction also blocks the interrupt at its own boundary.
    assign halt_now = halt_sw | ((cur == ST_F3) & hlt_instr);
    assign en_eff   = (int_enable | ion_armed) & ~iof_set;
    assign take_int = boundary & ~halt_now & int_req & en_eff;

    always_comb begin
        nxt      = ST_H0;
        boundary = 1'b0;
        case (cur)
            ST_F0: nxt = mem_busy ? ST_FW : ST_F1;
            ST_FW: nxt = mem_busy ? ST_FW : ST_F1;
            ST_F1: nxt = ST_F2;
            ST_F2: nxt = ST_F3;
            ST_F3: begin
                if (ind && (op <= 3'd5))
                    nxt = ST_D0;
                else if (op <= 3'd4)
                    nxt = ST_E0;
                else
                    boundary = 1'b1;
            end
            ST_D0: nxt = mem_busy ? ST_D0 : ST_D1;
            ST_D1: nxt = ST_D2;
            ST_D2: nxt = ST_D3;
            ST_D3: begin
                if (op == 3'd5)
                    boundary = 1'b1;
                else
                    nxt = ST_E0;
            end
            ST_E0: nxt = mem_busy ? ST_E0 : ST_E1;
            ST_E1: nxt = ST_E2;
            ST_E2: nxt = ST_E3;
            ST_E3: boundary = 1'b1;
            ST_H0: nxt = cont_pulse ? ST_H1 : ST_H0;
            ST_H1: nxt = ST_H2;
            ST_H2: nxt = ST_H3;
            ST_H3: nxt = ST_F0;
            default: nxt = ST_H0;
        endcase

        if (boundary) begin
            if (halt_now)
                nxt = ST_H0;
            else if (take_int)
                nxt = ST_E0;
            else if (step_now)
                nxt = ST_H0;
            else
                nxt = ST_F0;
        end
    end

    // instr_done is registered, so flag the last state as it is entered.
    always_comb begin
        done_nx = 1'b0;
        case (nxt)
            ST_F3:   done_nx = (op >= 3'd6) || ((op == 3'd5) && !ind);
            ST_D3:   done_nx = (op == 3'd5);
            ST_E3:   done_nx = 1'b1;
            default: done_nx = 1'b0;
        endcase
    end

    assign halt_nx = (nxt == ST_H0) || (nxt == ST_H1) || (nxt == ST_H2) || (nxt == ST_H3);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= START_HALTED ? ST_H0 : ST_F0;
            run         <= !START_HALTED;
            instr_done  <= 1'b0;
            int_in_prog <= 1'b0;
            int_enable  <= 1'b0;
            ion_pending <= 1'b0;
            ion_armed   <= 1'b0;
        end else begin
            cur        <= nxt;
            run        <= !halt_nx;
            instr_done <= done_nx;

            if (take_int)
                int_in_prog <= 1'b1;
            else if (boundary)
                int_in_prog <= 1'b0;

            // ION: pending until its own boundary, armed for one more instruction, then enabled.
            if (iof_set) begin
                int_enable  <= 1'b0;
                ion_pending <= 1'b0;
                ion_armed   <= 1'b0;
            end else if (boundary) begin
                int_enable  <= take_int ? 1'b0 : (int_enable | ion_armed);
                ion_armed   <= ion_pending | ion_set;
                ion_pending <= 1'b0;
            end else if (ion_set) begin
                ion_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_major_state_seq.sv
// Bench for major_state_seq: directed scenarios plus random instruction streams against an instruction-level model.
module tb_major_state_seq;

    localparam logic [4:0] F0 = 5'h00, F1 = 5'h01, F2 = 5'h02, F3 = 5'h03, FW = 5'h04;
    localparam logic [4:0] D0 = 5'h08, D1 = 5'h09, D2 = 5'h0A, D3 = 5'h0B;
    localparam logic [4:0] E0 = 5'h10, E1 = 5'h11, E2 = 5'h12, E3 = 5'h13;
    localparam logic [4:0] H0 = 5'h18, H1 = 5'h19, H2 = 5'h1A, H3 = 5'h1B;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] instruction = 12'o0000;
    logic        mem_busy = 1'b0, int_req = 1'b0, ion_set = 1'b0, iof_set = 1'b0;
    logic        hlt_instr = 1'b0, halt_sw = 1'b0, cont_pulse = 1'b0;
    bit          g_step = 1'b0;
    logic [4:0]  state, state2;
    logic        int_in_prog, int_enable, run, instr_done;
    logic        iip2, en2, run2, done2;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  m_en = 1'b0;
    int  m_delay = 0;
    int  f;

    major_state_seq #(.START_HALTED(1'b1)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .mem_busy(mem_busy),
        .int_req(int_req), .ion_set(ion_set), .iof_set(iof_set), .hlt_instr(hlt_instr),
        .halt_sw(halt_sw), .cont_pulse(cont_pulse), .sing_step_sw(g_step),
        .state(state), .int_in_prog(int_in_prog), .int_enable(int_enable),
        .run(run), .instr_done(instr_done)
    );

    major_state_seq #(.START_HALTED(1'b0)) dut_run (
        .clk(clk), .reset(reset), .instruction(instruction), .mem_busy(mem_busy),
        .int_req(int_req), .ion_set(ion_set), .iof_set(iof_set), .hlt_instr(hlt_instr),
        .halt_sw(halt_sw), .cont_pulse(cont_pulse), .sing_step_sw(g_step),
        .state(state2), .int_in_prog(iip2), .int_enable(en2),
        .run(run2), .instr_done(done2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit is_h(input logic [4:0] s);
        return (s == H0) || (s == H1) || (s == H2) || (s == H3);
    endfunction

    task automatic step_chk(input logic [4:0] es, input bit ed, input bit ei, input bit ee, input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_state"}, state, es);
        chk_b({tag, "_run"}, run, !is_h(es));
        chk_b({tag, "_done"}, instr_done, ed);
        chk_b({tag, "_iip"}, int_in_prog, ei);
        chk_b({tag, "_ien"}, int_enable, ee);
    endtask

    // One instruction (or forced JMS) from its first state to the boundary edge.
    // nxt: 0 = next instruction at F0, 1 = interrupt taken, 2 = halted.
    task automatic do_seq(input logic [11:0] ins, input bit forced, input int wf, input int wd,
                          input int we, input int ion_k, input int iof_k, input bit hlt,
                          input bit hsw, input bit irq, output int nxt);
        logic [4:0] lst[$];
        bit         bsy[$];
        logic [2:0] op;
        bit         ind, halt, bnd_int;
        int         last;
        op  = ins[11:9];
        ind = ins[8];
        nxt = 0;
        if (!forced) begin
            lst.push_back(F0); bsy.push_back(wf > 0);
            for (int i = 0; i < wf; i++) begin lst.push_back(FW); bsy.push_back(i < wf - 1); end
            lst.push_back(F1); bsy.push_back(1'b0);
            lst.push_back(F2); bsy.push_back(1'b0);
            lst.push_back(F3); bsy.push_back(1'b0);
            if (ind && op <= 3'd5) begin
                for (int i = 0; i <= wd; i++) begin lst.push_back(D0); bsy.push_back(i < wd); end
                lst.push_back(D1); bsy.push_back(1'b0);
                lst.push_back(D2); bsy.push_back(1'b0);
                lst.push_back(D3); bsy.push_back(1'b0);
            end
        end
        if (forced || op <= 3'd4) begin
            for (int i = 0; i <= we; i++) begin lst.push_back(E0); bsy.push_back(i < we); end
            lst.push_back(E1); bsy.push_back(1'b0);
            lst.push_back(E2); bsy.push_back(1'b0);
            lst.push_back(E3); bsy.push_back(1'b0);
        end
        last = lst.size() - 1;
        instruction = ins;
        for (int k = 0; k <= last; k++) begin
            mem_busy   = bsy[k];
            hlt_instr  = hlt && (lst[k] == F3);
            ion_set    = (k == ion_k);
            iof_set    = (k == iof_k);
            cont_pulse = ($urandom % 5 == 0);
            halt_sw    = hsw;
            int_req    = irq;
            if (k == iof_k) begin
                m_en = 1'b0;
                m_delay = 0;
            end else if (k == ion_k) begin
                m_delay = 2;
            end
            if (k < last) begin
                step_chk(lst[k + 1], (k + 1) == last, forced, m_en, "seq");
            end else begin
                if (m_delay > 0) begin
                    m_delay--;
                    if (m_delay == 0) m_en = 1'b1;
                end
                halt    = hsw || (hlt && lst[last] == F3);
                bnd_int = 1'b0;
                if (halt) nxt = 2;
                else if (irq && m_en) begin nxt = 1; m_en = 1'b0; bnd_int = 1'b1; end
                else if (g_step) nxt = 2;
                else nxt = 0;
                step_chk(bnd_int ? E0 : (nxt == 2 ? H0 : F0), 1'b0, bnd_int, m_en, "bnd");
            end
        end
        mem_busy = 1'b0; hlt_instr = 1'b0; ion_set = 1'b0; iof_set = 1'b0;
        cont_pulse = 1'b0; halt_sw = 1'b0;
    endtask

    task automatic do_halt(input int idle);
        for (int i = 0; i < idle; i++) begin
            cont_pulse = 1'b0;
            halt_sw = 1'($urandom % 2);
            step_chk(H0, 1'b0, 1'b0, m_en, "h0");
        end
        cont_pulse = 1'b1;
        step_chk(H1, 1'b0, 1'b0, m_en, "h1");
        cont_pulse = 1'($urandom % 2); halt_sw = 1'($urandom % 2);
        step_chk(H2, 1'b0, 1'b0, m_en, "h2");
        cont_pulse = 1'($urandom % 2); halt_sw = 1'($urandom % 2);
        step_chk(H3, 1'b0, 1'b0, m_en, "h3");
        cont_pulse = 1'($urandom % 2); halt_sw = 1'($urandom % 2);
        step_chk(F0, 1'b0, 1'b0, m_en, "hf0");
        cont_pulse = 1'b0; halt_sw = 1'b0;
    endtask

    // Full instruction including any interrupt entry and halt/restart; first = boundary outcome.
    task automatic full_instr(input logic [11:0] ins, input int wf, input int wd, input int we,
                              input int ion_k, input int iof_k, input bit hlt, input bit hsw,
                              input bit irq, output int first);
        int nxt;
        do_seq(ins, 1'b0, wf, wd, we, ion_k, iof_k, hlt, hsw, irq, nxt);
        first = nxt;
        if (nxt == 1) do_seq(ins, 1'b1, 0, 0, int'($urandom % 3), -1, -1, 1'b0, hsw, irq, nxt);
        if (nxt == 2) do_halt(int'($urandom % 3));
    endtask

    initial begin
        logic [11:0] ins;
        int ion_k, iof_k;

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_state", state, H0);
        chk_b("rst_run", run, 1'b0);
        chk_b("rst_done", instr_done, 1'b0);
        chk_b("rst_iip", int_in_prog, 1'b0);
        chk_b("rst_ien", int_enable, 1'b0);
        chk("rst_state_run", state2, F0);
        chk_b("rst_run_run", run2, 1'b1);
        reset = 1'b0;

        do_halt(2);
        full_instr(12'o1200, 3, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, f);
        chk_i("tad_next", f, 0);
        full_instr(12'o5600, 0, 1, 0, -1, -1, 1'b0, 1'b0, 1'b0, f);
        chk_i("jmpi_next", f, 0);
        full_instr(12'o5200, 0, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, f);
        chk_i("jmp_next", f, 0);

        full_instr(12'o6001, 0, 0, 0, 3, -1, 1'b0, 1'b0, 1'b1, f);
        chk_i("ion_a_next", f, 0);
        full_instr(12'o1200, 0, 0, 1, -1, -1, 1'b0, 1'b0, 1'b1, f);
        chk_i("ion_b_int", f, 1);

        full_instr(12'o6001, 0, 0, 0, 3, 3, 1'b0, 1'b0, 1'b1, f);
        chk_i("ioniof_a", f, 0);
        for (int i = 0; i < 3; i++) begin
            full_instr(12'o1200, 0, 0, 0, -1, -1, 1'b0, 1'b0, 1'b1, f);
            chk_i("ioniof_noint", f, 0);
        end

        full_instr(12'o7402, 0, 0, 0, -1, -1, 1'b1, 1'b0, 1'b0, f);
        chk_i("hlt_next", f, 2);
        full_instr(12'o1200, 1, 0, 0, -1, -1, 1'b0, 1'b1, 1'b0, f);
        chk_i("halt_sw_next", f, 2);

        for (int n = 0; n < 150; n++) begin
            ins   = 12'($urandom);
            ion_k = (m_delay == 0 && !m_en && $urandom % 5 == 0) ? int'($urandom % 6) : -1;
            iof_k = ($urandom % 8 == 0) ? int'($urandom % 6) : -1;
            full_instr(ins, int'($urandom % 3), int'($urandom % 3), int'($urandom % 3), ion_k, iof_k,
                       (ins[11:9] == 3'd7) && ($urandom % 10 == 0), ($urandom % 12 == 0),
                       ($urandom % 3 != 0), f);
        end

        full_instr(12'o6002, 0, 0, 0, -1, 3, 1'b0, 1'b0, 1'b0, f);
        full_instr(12'o6001, 0, 0, 0, 3, -1, 1'b0, 1'b0, 1'b0, f);
        full_instr(12'o1200, 0, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, f);
        instruction = 12'o1200;
        step_chk(F1, 1'b0, 1'b0, m_en, "mid");
        step_chk(F2, 1'b0, 1'b0, m_en, "mid");
        step_chk(F3, 1'b0, 1'b0, m_en, "mid");
        step_chk(E0, 1'b0, 1'b0, m_en, "mid");
        reset = 1'b1;
        m_en = 1'b0;
        m_delay = 0;
        step_chk(H0, 1'b0, 1'b0, 1'b0, "midrst");
        chk("midrst_state_run", state2, F0);
        reset = 1'b0;
        do_halt(1);
        full_instr(12'o2200, 0, 0, 0, -1, -1, 1'b0, 1'b0, 1'b1, f);
        chk_i("post_rst_noint", f, 0);

`ifdef SINGLE_STEP_EN
        g_step = 1'b1;
        full_instr(12'o1200, 0, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, f);
        chk_i("sstep_tad", f, 2);
        full_instr(12'o5600, 0, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, f);
        chk_i("sstep_jmpi", f, 2);
        full_instr(12'o7402, 0, 0, 0, -1, -1, 1'b1, 1'b1, 1'b0, f);
        chk_i("sstep_hlt", f, 2);
        g_step = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
